// File: rtl/shamt_serial_shifter_pkg.sv
// Shared definitions for the serial shift unit.
// Contents: op encodings, FSM state encoding, shift-count width constant.
// Optional feature macro used by this slice: SHAMT_SHIFTER_ROTATE_EN.
package shifter_pkg;

   localparam int SHAMT_W = 5;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/shamt_serial_shifter_if.sv
// Handshake/data bundle between the control FSM and the serial shifter.
// Signals: start, op[1:0], data_in[WIDTH-1:0], amount_in[31:0] (requester side),
//          result[WIDTH-1:0], busy, done, ready (shifter side).
// Modports: master = requester, slave = shifter.
interface shamt_serial_shifter_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] data_in;
   logic [31:0]      amount_in;
   logic [WIDTH-1:0] result;
   logic             busy;
   logic             done;
   logic             ready;

   modport master (
      output start, op, data_in, amount_in,
      input  result, busy, done, ready
   );

   modport slave (
      input  start, op, data_in, amount_in,
      output result, busy, done, ready
   );
endinterface

// File: rtl/shamt_serial_shifter_shift_step.sv
// shift_step: combinational one-bit-position shift of the working value.
// Ports: op[1:0] (latched operation), value_in[WIDTH-1:0], value_out[WIDTH-1:0].
// With SHAMT_SHIFTER_ROTATE_EN defined, op=11 rotates right; otherwise it
// decodes as a logical right shift and no rotate path exists.
module shift_step
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] value_in,
   output logic [WIDTH-1:0] value_out
);

   // Select the single-bit shift for the latched operation.
   always_comb begin
      value_out = value_in;
      case (op)
         OP_SLL:  value_out = {value_in[WIDTH-2:0], 1'b0};
         OP_SRL:  value_out = {1'b0, value_in[WIDTH-1:1]};
         OP_SRA:  value_out = {value_in[WIDTH-1], value_in[WIDTH-1:1]};
`ifdef SHAMT_SHIFTER_ROTATE_EN
         OP_ROR:  value_out = {value_in[0], value_in[WIDTH-1:1]};
`else
         OP_ROR:  value_out = {1'b0, value_in[WIDTH-1:1]};
`endif
         default: value_out = value_in;
      endcase
   end

endmodule

// File: rtl/shamt_serial_shifter.sv
// shamt_serial_shifter: multi-cycle MIPS shift unit, one bit position per clock.
// Ports: clk, rst (async, active-high), bus (shamt_serial_shifter_if.slave):
//   start/op/data_in/amount_in in; result/busy/done/ready out.
// Only amount_in[CNT_W-1:0] is used, matching MIPS variable-shift semantics.
// Optional feature: SHAMT_SHIFTER_ROTATE_EN enables rotate-right on op=11.
module shamt_serial_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = SHAMT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   shamt_serial_shifter_if.slave bus
);

   state_e           state_r;
   state_e           state_next_s;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_load_s;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] result_r;
   logic [WIDTH-1:0] step_s;
   logic             load_s;
   logic             shift_s;
   logic             busy_r;
   logic             done_r;
   logic             ready_r;
   logic             unused_amount_s;

   assign count_load_s    = bus.amount_in[CNT_W-1:0];
   assign unused_amount_s = ^bus.amount_in[31:CNT_W];

   shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .op        (op_r),
      .value_in  (result_r),
      .value_out (step_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode plus load/shift strobes for the datapath.
   always_comb begin
      state_next_s = state_r;
      load_s       = 1'b0;
      shift_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               load_s = 1'b1;
               if (count_load_s == {CNT_W{1'b0}}) begin
                  state_next_s = DONE;
               end else begin
                  state_next_s = SHIFT;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         SHIFT: begin
            shift_s = 1'b1;
            if (count_r == CNT_W'(1)) begin
               state_next_s = DONE;
            end else begin
               state_next_s = SHIFT;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Operand/op/count capture on accept, then one shift step per SHIFT cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_r <= {WIDTH{1'b0}};
         op_r     <= 2'b00;
         count_r  <= {CNT_W{1'b0}};
      end else if (load_s) begin
         result_r <= bus.data_in;
         op_r     <= bus.op;
         count_r  <= count_load_s;
      end else if (shift_s) begin
         result_r <= step_s;
         count_r  <= count_r - CNT_W'(1);
      end else begin
         result_r <= result_r;
         op_r     <= op_r;
         count_r  <= count_r;
      end
   end

   // Status flags registered from the next state so they line up with state_r.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         ready_r <= 1'b1;
      end else begin
         busy_r  <= (state_next_s == SHIFT);
         done_r  <= (state_next_s == DONE);
         ready_r <= (state_next_s == IDLE);
      end
   end

   assign bus.result = result_r;
   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.ready  = ready_r;

endmodule

// File: tb/tb_shamt_serial_shifter.sv
// Self-checking bench for shamt_serial_shifter: scoreboard of expected
// result/latency pushed at start, popped when done is observed.
module tb_shamt_serial_shifter;

   localparam int WIDTH = 32;

   typedef struct {
      logic [31:0] res;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   shamt_serial_shifter_if #(.WIDTH(WIDTH)) bus ();

   shamt_serial_shifter #(.WIDTH(WIDTH), .CNT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] d, input logic [31:0] amt, input logic [1:0] op);
      int n;
      n = int'(amt[4:0]);
      case (op)
         2'b00:   return d << n;
         2'b01:   return d >> n;
         2'b10:   return $unsigned($signed(d) >>> n);
`ifdef SHAMT_SHIFTER_ROTATE_EN
         default: return (d >> n) | (d << (32 - n));
`else
         default: return d >> n;
`endif
      endcase
   endfunction

   // glitch=1: extra start during SHIFT (cycle 2) and start held during DONE.
   task automatic run_op(input string tag, input logic [31:0] d, input logic [31:0] amt,
                         input logic [1:0] op, input bit glitch);
      exp_t e;
      exp_t got;
      int   cyc;
      int   busy_cnt;
      bit   seen;
      e.res = model(d, amt, op);
      e.lat = (amt[4:0] == 5'd0) ? 1 : int'(amt[4:0]) + 1;
      sb.push_back(e);
      @(negedge clk);
      check_val({tag, "_ready_before"}, 64'(bus.ready), 64'd1);
      bus.start     = 1'b1;
      bus.data_in   = d;
      bus.amount_in = amt;
      bus.op        = op;
      cyc      = 0;
      busy_cnt = 0;
      seen     = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         bus.start     = 1'b0;
         bus.data_in   = ~d;
         bus.amount_in = amt + 32'd3;
         bus.op        = op ^ 2'b01;
         if (glitch && cyc == 2) begin
            bus.start   = 1'b1;
            bus.data_in = 32'h1234_5678;
         end
         if (bus.busy) busy_cnt++;
         if (bus.done) seen = 1'b1;
      end
      if (!seen) begin
         check_val({tag, "_timeout"}, 64'd0, 64'd1);
         void'(sb.pop_front());
         return;
      end
      got = sb.pop_front();
      check_val({tag, "_result"}, 64'(bus.result), 64'(got.res));
      check_val({tag, "_latency"}, 64'(cyc), 64'(got.lat));
      check_val({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(got.lat - 1));
      if (glitch) begin
         bus.start   = 1'b1;
         bus.data_in = 32'hCAFE_0000;
      end
      @(negedge clk);
      bus.start = 1'b0;
      check_val({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
      check_val({tag, "_ready_after"}, 64'(bus.ready), 64'd1);
      check_val({tag, "_result_held"}, 64'(bus.result), 64'(got.res));
   endtask

   initial begin
      int  done_seen;
      logic [31:0] rd;
      logic [31:0] ra;
      logic [1:0]  ro;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.op        = 2'b00;
      bus.data_in   = 32'd0;
      bus.amount_in = 32'd0;
      #12;
      check_val("rst_result", 64'(bus.result), 64'd0);
      check_val("rst_busy", 64'(bus.busy), 64'd0);
      check_val("rst_done", 64'(bus.done), 64'd0);
      check_val("rst_ready", 64'(bus.ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;

      run_op("sll4", 32'h0000_0001, 32'h0000_0004, 2'b00, 1'b0);
      run_op("sra31", 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 1'b0);
      run_op("srl0", 32'hDEAD_BEEF, 32'h0000_0020, 2'b01, 1'b0);

      // Abort an operation with reset mid-shift.
      @(negedge clk);
      bus.start     = 1'b1;
      bus.data_in   = 32'hF000_000F;
      bus.amount_in = 32'd8;
      bus.op        = 2'b01;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("abort_result", 64'(bus.result), 64'd0);
      check_val("abort_busy", 64'(bus.busy), 64'd0);
      check_val("abort_ready", 64'(bus.ready), 64'd1);
      check_val("abort_done", 64'(bus.done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done) done_seen++;
      end
      check_val("abort_no_done", 64'(done_seen), 64'd0);

      run_op("after_abort", 32'hF000_000F, 32'd8, 2'b01, 1'b0);
      run_op("ignore_start", 32'h0000_FF00, 32'd6, 2'b01, 1'b1);
      run_op("op11", 32'h0000_0001, 32'd1, 2'b11, 1'b0);
      run_op("sra_pos", 32'h4000_0000, 32'd3, 2'b10, 1'b0);

      for (int k = 0; k < 6; k++) begin
         rd = $urandom;
         ra = $urandom;
         ro = 2'($urandom_range(0, 3));
         run_op($sformatf("rand%0d", k), rd, ra, ro, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
